// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with hold timeout that muxes one data bit from the owner.
// Define MUX4_ARB_FIXED_PRIO_EN to switch winner selection to fixed priority (lowest index first).
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic       w_any;
    logic       w_arb;
    logic [1:0] w_win;

    assign w_any = |req;
    assign w_arb = !req[r_sel] || (r_cnt == 4'(MAX_HOLD));

`ifdef MUX4_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = 2'd0;
        for (int unsigned k = 4; k > 0; k--) begin
            if (req[k-1]) w_win = 2'(k - 1);
        end
    end
`else
    // r_last always equals r_sel while granted, so one search start covers both
    // the idle case and the "owner searched last" rule at an arbitration point.
    always_comb begin
        logic [1:0] w_idx;
        w_win = 2'd0;
        w_idx = 2'd0;
        for (int unsigned k = 4; k > 0; k--) begin
            w_idx = r_last + 2'd1 + 2'(k - 1);
            if (req[w_idx]) w_win = w_idx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_cnt   <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = 4'd1;
                    w_last_nxt  = w_win;
                end
            end
            GRANT: begin
                if (w_arb) begin
                    if (w_any) begin
                        w_sel_nxt  = w_win;
                        w_cnt_nxt  = 4'd1;
                        w_last_nxt = w_win;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (r_state == GRANT);
        sel   = r_sel;
        gnt   = valid ? (4'b0001 << r_sel) : '0;
        y     = valid & d[r_sel];
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: driver queues expected outputs, monitor checks them.
// Define MUX4_ARB_FIXED_PRIO_EN for both files to exercise the fixed-priority build.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       y;
        logic [3:0] cnt;
        logic       full;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    // Drives one cycle of inputs and queues the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dd,
                        input logic [3:0] eg, input logic [1:0] es, input logic ev,
                        input logic ey, input logic [3:0] ec, input logic ef, input string nm);
        exp_t e;
        rst = r;
        req = rq;
        d   = dd;
        e.gnt = eg; e.sel = es; e.valid = ev; e.y = ey; e.cnt = ec; e.full = ef;
        q.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        logic  bad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                bad = (gnt !== e.gnt) || (valid !== e.valid) || (y !== e.y);
                if (e.valid || e.full)
                    bad = bad || (sel !== e.sel) || (dut.r_cnt !== e.cnt);
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b sel=%0d valid=%b y=%b cnt=%0d, want gnt=%b sel=%0d valid=%b y=%b cnt=%0d",
                             nm, gnt, sel, valid, y, dut.r_cnt, e.gnt, e.sel, e.valid, e.y, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] dv;
        rst = 1'b1; req = '0; d = '0;
        step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, "reset");

        // Full rotation, 4 cycles per owner, y follows d = 1010
        dv = 4'b1010;
        for (int k = 0; k < 4; k++)
            for (int c = 1; c <= 4; c++)
                step(0, 4'b1111, dv, 4'b0001 << k, 2'(k), 1, dv[k], 4'(c), 1, "rotate");
        step(0, 4'b1111, dv, 4'b0001, 0, 1, 0, 1, 1, "rotate_wrap");
        step(1, 4'b1111, dv, 4'b0000, 0, 0, 0, 0, 1, "reset_ignores_req");

        // Single short request then release to IDLE
        step(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, 1, 1, "short_req_c1");
        step(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, 2, 1, "short_req_c2");
        step(0, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, "release_idle");
        step(0, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, "idle_stays");

        // Lone requester: continuous grant, counter reloads every 4 cycles
        for (int i = 0; i < 9; i++)
            step(0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 4'((i % 4) + 1), 1, "lone_hold");
        step(0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, "lone_release");

        // Mid-grant request does not preempt; handoff on release has no bubble
        step(0, 4'b0010, 4'b1000, 4'b0010, 1, 1, 0, 1, 1, "own1_c1");
        step(0, 4'b1010, 4'b1000, 4'b0010, 1, 1, 0, 2, 1, "no_preempt");
        step(0, 4'b1000, 4'b1000, 4'b1000, 3, 1, 1, 1, 1, "handoff_3");
        step(0, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0, 0, 0, "handoff_idle");

        // Reset during GRANT of requester 2, then requester 0 wins first
        step(0, 4'b0100, 4'b0101, 4'b0100, 2, 1, 1, 1, 1, "own2_c1");
        step(0, 4'b0100, 4'b0101, 4'b0100, 2, 1, 1, 2, 1, "own2_c2");
        step(1, 4'b0100, 4'b0101, 4'b0000, 0, 0, 0, 0, 1, "reset_mid_grant");
        step(0, 4'b1111, 4'b1010, 4'b0001, 0, 1, 0, 1, 1, "post_reset_first");
        step(0, 4'b1111, 4'b1010, 4'b0001, 0, 1, 0, 2, 1, "post_reset_c2");
        step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, "reset2");

        // req = 1011 held for 12 cycles
        for (int i = 0; i < 12; i++) begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
            step(0, 4'b1011, 4'b0001, 4'b0001, 0, 1, 1, 4'((i % 4) + 1), 1, "fixed_prio");
`else
            step(0, 4'b1011, 4'b0001, (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b1000,
                 (i < 4) ? 2'd0 : (i < 8) ? 2'd1 : 2'd3, 1, (i < 4) ? 1'b1 : 1'b0,
                 4'((i % 4) + 1), 1, "rr_skip2");
`endif
        end
        step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, "final_reset");

        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
